// File: rtl/retire_order_pkg.sv
// Shared pipeline widths plus the id-sequence helpers used by the retirement buffer.
// Ids are nonzero and wrap from 2^w-1 back to 1.
package retire_order_pkg;

  localparam int INSTRUCTION_ID_WIDTH = 4;
  localparam int ADDR_WIDTH           = 32;
  localparam int NUM_REGISTERS_LOG2   = 5;
  localparam int DATA_WIDTH           = 32;
  localparam int ROB_DEPTH            = 8;

  function automatic logic [31:0] id_next(input logic [31:0] i, input int w);
    logic [31:0] id_max;
    id_max = (32'd1 << w) - 32'd1;
    return (i == id_max) ? 32'd1 : i + 32'd1;
  endfunction

  // Distance along the id sequence; the wrap skips id 0, hence the extra -1.
  function automatic logic [31:0] id_dist(input logic [31:0] h, input logic [31:0] i, input int w);
    if (i >= h) return i - h;
    return i - h - 32'd1 + (32'd1 << w);
  endfunction

endpackage

// File: rtl/retire_order_if.sv
// Completion inputs from both execution pipes and the two registered retire slots.
interface retire_order_if import retire_order_pkg::*; #(
  parameter int ID_W   = INSTRUCTION_ID_WIDTH,
  parameter int DATA_W = DATA_WIDTH
);
  logic [ID_W-1:0]               cmp0_id,   cmp1_id;
  logic [ADDR_WIDTH-1:0]         cmp0_pc,   cmp1_pc;
  logic                          cmp0_wen,  cmp1_wen;
  logic [NUM_REGISTERS_LOG2-1:0] cmp0_rd,   cmp1_rd;
  logic [DATA_W-1:0]             cmp0_data, cmp1_data;

  logic [ID_W-1:0]               ret0_id,   ret1_id;
  logic [ADDR_WIDTH-1:0]         ret0_pc,   ret1_pc;
  logic                          ret0_wen,  ret1_wen;
  logic [NUM_REGISTERS_LOG2-1:0] ret0_rd,   ret1_rd;
  logic [DATA_W-1:0]             ret0_data, ret1_data;

  modport master (
    output cmp0_id, cmp0_pc, cmp0_wen, cmp0_rd, cmp0_data,
    output cmp1_id, cmp1_pc, cmp1_wen, cmp1_rd, cmp1_data,
    input  ret0_id, ret0_pc, ret0_wen, ret0_rd, ret0_data,
    input  ret1_id, ret1_pc, ret1_wen, ret1_rd, ret1_data
  );

  modport slave (
    input  cmp0_id, cmp0_pc, cmp0_wen, cmp0_rd, cmp0_data,
    input  cmp1_id, cmp1_pc, cmp1_wen, cmp1_rd, cmp1_data,
    output ret0_id, ret0_pc, ret0_wen, ret0_rd, ret0_data,
    output ret1_id, ret1_pc, ret1_wen, ret1_rd, ret1_data
  );
endinterface

// File: rtl/rob_entry_array.sv
// DEPTH-entry window storage: two write ports, two read ports, per-read-port clear.
// Only the valid bits are reset; payload is qualified by valid.
module rob_entry_array #(
  parameter int DEPTH = 8,
  parameter int PW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr_all,
  input  logic                     i_we0,
  input  logic [$clog2(DEPTH)-1:0] i_wslot0,
  input  logic [PW-1:0]            i_wdata0,
  input  logic                     i_we1,
  input  logic [$clog2(DEPTH)-1:0] i_wslot1,
  input  logic [PW-1:0]            i_wdata1,
  input  logic [1:0]               i_clr,
  input  logic [$clog2(DEPTH)-1:0] i_rslot0,
  input  logic [$clog2(DEPTH)-1:0] i_rslot1,
  output logic [DEPTH-1:0]         o_valid,
  output logic [PW-1:0]            o_rdata0,
  output logic [PW-1:0]            o_rdata1
);
  localparam int SW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_data [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_clr_all) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((i_we0 && i_wslot0 == SW'(i)) || (i_we1 && i_wslot1 == SW'(i)))
          r_valid[i] <= 1'b1;
        else if ((i_clr[0] && i_rslot0 == SW'(i)) || (i_clr[1] && i_rslot1 == SW'(i)))
          r_valid[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_we0) r_data[i_wslot0] <= i_wdata0;
    if (i_we1) r_data[i_wslot1] <= i_wdata1;
  end

  assign o_valid  = r_valid;
  assign o_rdata0 = r_data[i_rslot0];
  assign o_rdata1 = r_data[i_rslot1];
endmodule

// File: rtl/retire_order.sv
// In-order retirement buffer: collects out-of-order completions by id and
// retires up to two instructions per cycle in program order.
module retire_order import retire_order_pkg::*; #(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int ID_W   = INSTRUCTION_ID_WIDTH,
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ID_W-1:0]   flush_id,
  retire_order_if.slave     bus,
  output logic [ID_W-1:0]   head_id,
  output logic              order_error
);
  localparam int SW = $clog2(DEPTH);
  localparam int PW = ID_W + ADDR_WIDTH + 1 + NUM_REGISTERS_LOG2 + DATA_W;

  logic [ID_W-1:0]  r_head_id;
  logic [SW-1:0]    r_head_slot;
  logic             r_order_error;
  logic [PW-1:0]    r_ret0, r_ret1;

  logic [DEPTH-1:0] w_valid;
  logic [31:0]      w_dist0, w_dist1;
  logic [SW-1:0]    w_slot0, w_slot1, w_rslot1;
  logic             w_acc0, w_acc1, w_dup, w_err, w_ret0, w_ret1;
  logic [PW-1:0]    w_cpl0, w_cpl1, w_rent0, w_rent1;
  logic [ID_W-1:0]  w_head_n1, w_head_n2;

  assign w_cpl0 = {bus.cmp0_id, bus.cmp0_pc, bus.cmp0_wen, bus.cmp0_rd, bus.cmp0_data};
  assign w_cpl1 = {bus.cmp1_id, bus.cmp1_pc, bus.cmp1_wen, bus.cmp1_rd, bus.cmp1_data};

  // Window placement: slot offset from head equals id distance from head_id.
  assign w_dist0 = id_dist(32'(r_head_id), 32'(bus.cmp0_id), ID_W);
  assign w_dist1 = id_dist(32'(r_head_id), 32'(bus.cmp1_id), ID_W);
  assign w_slot0 = r_head_slot + w_dist0[SW-1:0];
  assign w_slot1 = r_head_slot + w_dist1[SW-1:0];

  assign w_dup  = (bus.cmp1_id != '0) && (bus.cmp1_id == bus.cmp0_id);
  assign w_acc0 = (bus.cmp0_id != '0) && (w_dist0 < 32'(DEPTH)) && !w_valid[w_slot0];
  assign w_acc1 = (bus.cmp1_id != '0) && !w_dup && (w_dist1 < 32'(DEPTH)) && !w_valid[w_slot1];
  assign w_err  = ((bus.cmp0_id != '0) && !w_acc0) || ((bus.cmp1_id != '0) && !w_acc1);

  // Retire looks only at stored valids, so a completion never bypasses to ret*.
  assign w_rslot1 = r_head_slot + SW'(1);
  assign w_ret0   = w_valid[r_head_slot];
  assign w_ret1   = w_ret0 && w_valid[w_rslot1];

  assign w_head_n1 = ID_W'(id_next(32'(r_head_id), ID_W));
  assign w_head_n2 = ID_W'(id_next(32'(w_head_n1), ID_W));

  rob_entry_array #(.DEPTH(DEPTH), .PW(PW)) u_entries (
    .clk      (clk),
    .rst      (reset),
    .i_clr_all(flush),
    .i_we0    (w_acc0 && !flush),
    .i_wslot0 (w_slot0),
    .i_wdata0 (w_cpl0),
    .i_we1    (w_acc1 && !flush),
    .i_wslot1 (w_slot1),
    .i_wdata1 (w_cpl1),
    .i_clr    ({w_ret1, w_ret0} & {2{!flush}}),
    .i_rslot0 (r_head_slot),
    .i_rslot1 (w_rslot1),
    .o_valid  (w_valid),
    .o_rdata0 (w_rent0),
    .o_rdata1 (w_rent1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head_id     <= ID_W'(1);
      r_head_slot   <= '0;
      r_order_error <= 1'b0;
      r_ret0        <= '0;
      r_ret1        <= '0;
    end else if (flush) begin
      r_head_id   <= flush_id;
      r_head_slot <= '0;
      r_ret0      <= '0;
      r_ret1      <= '0;
    end else begin
      r_ret0 <= w_ret0 ? w_rent0 : '0;
      r_ret1 <= w_ret1 ? w_rent1 : '0;
      if (w_ret1) begin
        r_head_id   <= w_head_n2;
        r_head_slot <= r_head_slot + SW'(2);
      end else if (w_ret0) begin
        r_head_id   <= w_head_n1;
        r_head_slot <= r_head_slot + SW'(1);
      end
      if (w_err) r_order_error <= 1'b1;
    end
  end

  assign {bus.ret0_id, bus.ret0_pc, bus.ret0_wen, bus.ret0_rd, bus.ret0_data} = r_ret0;
  assign {bus.ret1_id, bus.ret1_pc, bus.ret1_wen, bus.ret1_rd, bus.ret1_data} = r_ret1;
  assign head_id     = r_head_id;
  assign order_error = r_order_error;
endmodule

// File: doc/retire_order.md
# retire_order

In-order retirement buffer at the back end of the dual-issue pipeline. The two execution pipes complete out of order relative to each other because issue swaps them through `first` and splits pairs. This block collects completions from both pipes by instruction id and retires up to two instructions per cycle in program order. Only then are register writes presented to the register file.

## Interface
Parameters:
- `DEPTH`, 8: entries in the window; power of two, 4..32.
- `ID_W`, `INSTRUCTION_ID_WIDTH`: id width.
- `DATA_W`, `DATA_WIDTH`: writeback data width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `flush`  in  1  synchronous discard of all in-flight entries.
- `flush_id`  in  ID_W  id of the first instruction after the flush; nonzero.
- `cmp0_id`, `cmp1_id`  in  ID_W  completing id per pipe; 0 = no completion.
- `cmp0_pc`, `cmp1_pc`  in  `ADDR_WIDTH`  pc of the completing instruction.
- `cmp0_wen`, `cmp1_wen`  in  1  instruction writes a register.
- `cmp0_rd`, `cmp1_rd`  in  `NUM_REGISTERS_LOG2`  destination register.
- `cmp0_data`, `cmp1_data`  in  DATA_W  writeback value.
- `ret0_*`, `ret1_*`  out  same widths as `cmp*_*` (`id`, `pc`, `wen`, `rd`, `data`)  retired instructions, registered; `ret*_id`=0 means empty slot.
- `head_id`  out  ID_W  oldest unretired id; issue must not release an id at distance ≥ DEPTH from it.
- `order_error`  out  1  sticky protocol-violation flag.

## Operation
- Id sequence: nonzero ids, next(i) = (i == 2^ID_W−1) ? 1 : i+1.
- Distance: dist(h,i) = (i ≥ h) ? i−h : i−h−1, computed modulo 2^ID_W, skipping 0.
- State: `DEPTH` entries (valid, id, pc, wen, rd, data), `head_id`, `head_slot`.
- Slot for a completing id = (head_slot + dist(head_id,id)) mod DEPTH.
- Completion (id ≠ 0):
  - If dist < DEPTH and the slot is invalid, write the entry and set valid.
  - If dist ≥ DEPTH, or the slot is already valid, drop the completion and set `order_error`.
- Both ports carrying the same nonzero id: port0 is written, port1 is dropped, `order_error` is set.
- Retire selection reads stored state only, never same-cycle completions:
  - Slot head_slot valid → retire on port 0.
  - Additionally, slot head_slot+1 (mod DEPTH) valid → retire on port 1.
  - Port 1 never retires without port 0.
- On retire of n (0..2) entries: clear those valids, advance head_id by n in the id sequence, advance head_slot by n mod DEPTH.
- A completion into a slot being retired in the same cycle cannot occur: it would have dist ≥ DEPTH. It is treated as out of window.
- Flush has priority over completions and retire:
  - All valids are cleared.
  - head_id = flush_id, head_slot = 0.
  - `ret*` outputs are zeroed at that edge.
  - `order_error` is unchanged.
- Reset values:
  - Entries invalid; head_id = 1, head_slot = 0.
  - All `ret*` outputs 0; `order_error` = 0.

## Timing
- A completion sampled at edge k is stored at edge k.
- Earliest retirement of that entry appears on `ret*` after edge k+1. Minimum latency is 2 edges; there is no bypass.
- `ret*` is valid for exactly one cycle per retired instruction. No backpressure; the register file always accepts.
- Throughput: 2 retirements/cycle when the window is contiguous.
- `head_id` reflects the post-retire value after each edge.
- Reset asserted mid-operation discards all entries immediately (asynchronous); outputs return to reset values without waiting for a clock.

## Structure
- Shared package/defines additions:
  - `ROB_DEPTH`
  - an `id_next` function
  - an `id_dist` function
- Reuse the existing `INSTRUCTION_ID_WIDTH`, `ADDR_WIDTH`, `NUM_REGISTERS_LOG2`, `DATA_WIDTH`.
- One sub-module, `rob_entry_array`: the DEPTH-entry storage with two write ports, two read ports and a two-bit clear. Keep distance/slot arithmetic and retire control in `retire_order`.

## Test plan
- **Reset/idle:** after reset, head_id=1, all `ret*_id`=0, order_error=0; no completions → outputs stay 0.
- **In-order pair:** cmp0_id=1, cmp1_id=2 in one cycle → two edges later, ret0_id=1, ret1_id=2 in the same cycle; head_id=3.
- **Reversed completion:** id 2 (wen=1, rd=5, data=0xAB) completes a cycle before id 1 → nothing retires until id 1 is stored; then ret0_id=1, ret1_id=2, ret1_rd=5, ret1_data=0xAB.
- **Id wrap:** ID_W=4, head_id=15, complete 15 and 1 → ret0_id=15, ret1_id=1, head_id=2; id 0 never appears.
- **Errors:**
  - cmp0_id=cmp1_id=3 → order_error=1, only the port0 payload retires.
  - An id at dist=DEPTH → dropped, order_error=1.
- **Flush:** entries for ids 4,5 stored, flush with flush_id=9 → next edge ret*=0, head_id=9; later completion of id 9 retires on ret0.
